// File: rtl/sme_multi_pat_buffer.sv
// Byte-serial string/pattern buffer feeding the string-matching engines.
// Loads one string and NUM_PAT pattern slots, then computes each slot's KMP failure function.
module sme_multi_pat_buffer #(
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned MAX_STR = 32,
  parameter int unsigned MAX_PAT = 8,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned SEL_W   = $clog2(NUM_PAT + 1),
  parameter int unsigned SLEN_W  = $clog2(MAX_STR + 1),
  parameter int unsigned PLEN_W  = $clog2(MAX_PAT + 1),
  parameter int unsigned FF_W    = $clog2(MAX_PAT)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_W-1:0]                 w_data,
  input  logic                              write,
  input  logic [SEL_W-1:0]                  w_sel,
  output logic                              w_ready,
  output logic [MAX_STR*BYTE_W-1:0]         str_reg,
  output logic [NUM_PAT*MAX_PAT*BYTE_W-1:0] pat_reg,
  output logic [SLEN_W-1:0]                 str_len,
  output logic [NUM_PAT*PLEN_W-1:0]         pat_len,
  output logic [NUM_PAT*MAX_PAT*FF_W-1:0]   ff_result,
  output logic                              valid,
  input  logic                              ack,
  output logic                              w_err
);

  localparam int unsigned SIDX_W = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;
  localparam int unsigned PIDX_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
  localparam int unsigned SLOT_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FF_CAL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   str_q [MAX_STR];
  logic [BYTE_W-1:0]   str_d [MAX_STR];
  logic [BYTE_W-1:0]   pat_q [NUM_PAT][MAX_PAT];
  logic [BYTE_W-1:0]   pat_d [NUM_PAT][MAX_PAT];
  logic [FF_W-1:0]     ff_q  [NUM_PAT][MAX_PAT];
  logic [FF_W-1:0]     ff_d  [NUM_PAT][MAX_PAT];
  logic [SLEN_W-1:0]   str_len_q, str_len_d;
  logic [PLEN_W-1:0]   pat_len_q [NUM_PAT];
  logic [PLEN_W-1:0]   pat_len_d [NUM_PAT];
  logic                w_err_q, w_err_d;
  logic                valid_q, valid_d;
  logic                w_ready_q, w_ready_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [PLEN_W-1:0]   i_q, i_d;
  logic [FF_W-1:0]     k_q, k_d;
  logic                setup_q, setup_d;

  logic [PLEN_W-1:0]   cur_len;
  logic [BYTE_W-1:0]   ch_i;
  logic [BYTE_W-1:0]   ch_k;
  logic                slot_done;

  // Next-state: byte loading, KMP engine and handshake.
  always_comb begin
    state_d   = state_q;
    str_d     = str_q;
    pat_d     = pat_q;
    ff_d      = ff_q;
    str_len_d = str_len_q;
    pat_len_d = pat_len_q;
    w_err_d   = w_err_q;
    slot_d    = slot_q;
    i_d       = i_q;
    k_d       = k_q;
    setup_d   = setup_q;
    slot_done = 1'b0;
    cur_len   = pat_len_q[slot_q];
    ch_i      = pat_q[slot_q][PIDX_W'(i_q)];
    ch_k      = pat_q[slot_q][PIDX_W'(k_q)];

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (write) begin
          if (state_q == S_IDLE) begin
            state_d   = S_LOAD;
            str_len_d = '0;
            w_err_d   = 1'b0;
            for (int unsigned s = 0; s < NUM_PAT; s++) pat_len_d[SLOT_W'(s)] = '0;
          end
          if (w_sel == '0) begin
            if (str_len_d < SLEN_W'(MAX_STR)) begin
              str_d[SIDX_W'(str_len_d)] = w_data;
              str_len_d = str_len_d + SLEN_W'(1);
            end else begin
              w_err_d = 1'b1;
            end
          end else if (32'(w_sel) > NUM_PAT) begin
            w_err_d = 1'b1;
          end else begin
            for (int unsigned s = 0; s < NUM_PAT; s++) begin
              if (32'(w_sel) == s + 1) begin
                if (pat_len_d[SLOT_W'(s)] < PLEN_W'(MAX_PAT)) begin
                  pat_d[SLOT_W'(s)][PIDX_W'(pat_len_d[SLOT_W'(s)])] = w_data;
                  pat_len_d[SLOT_W'(s)] = pat_len_d[SLOT_W'(s)] + PLEN_W'(1);
                end else begin
                  w_err_d = 1'b1;
                end
              end
            end
          end
        end else if (state_q == S_LOAD) begin
          state_d = S_FF_CAL;
          slot_d  = '0;
          setup_d = 1'b1;
        end
      end

      S_FF_CAL: begin
        if (setup_q) begin
          // Clear entries past the pattern end so stale results never leak out.
          for (int unsigned j = 0; j < MAX_PAT; j++) begin
            if (j >= 32'(cur_len)) ff_d[slot_q][PIDX_W'(j)] = '0;
          end
          ff_d[slot_q][0] = '0;
          i_d = PLEN_W'(1);
          k_d = '0;
          if (cur_len <= PLEN_W'(1)) slot_done = 1'b1;
          else                       setup_d   = 1'b0;
        end else if (ch_i == ch_k) begin
          k_d = k_q + FF_W'(1);
          ff_d[slot_q][PIDX_W'(i_q)] = k_q + FF_W'(1);
          i_d = i_q + PLEN_W'(1);
          if (i_q + PLEN_W'(1) >= cur_len) slot_done = 1'b1;
        end else if (k_q != '0) begin
          k_d = ff_q[slot_q][PIDX_W'(k_q - FF_W'(1))];
        end else begin
          ff_d[slot_q][PIDX_W'(i_q)] = '0;
          i_d = i_q + PLEN_W'(1);
          if (i_q + PLEN_W'(1) >= cur_len) slot_done = 1'b1;
        end

        if (slot_done) begin
          setup_d = 1'b1;
          if (slot_q == SLOT_W'(NUM_PAT - 1)) state_d = S_DONE;
          else                                slot_d  = slot_q + SLOT_W'(1);
        end
      end

      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    w_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    valid_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      str_q     <= '{default: '0};
      pat_q     <= '{default: '{default: '0}};
      ff_q      <= '{default: '{default: '0}};
      str_len_q <= '0;
      pat_len_q <= '{default: '0};
      w_err_q   <= 1'b0;
      valid_q   <= 1'b0;
      w_ready_q <= 1'b1;
      slot_q    <= '0;
      i_q       <= '0;
      k_q       <= '0;
      setup_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      str_q     <= str_d;
      pat_q     <= pat_d;
      ff_q      <= ff_d;
      str_len_q <= str_len_d;
      pat_len_q <= pat_len_d;
      w_err_q   <= w_err_d;
      valid_q   <= valid_d;
      w_ready_q <= w_ready_d;
      slot_q    <= slot_d;
      i_q       <= i_d;
      k_q       <= k_d;
      setup_q   <= setup_d;
    end
  end

  // Flatten storage onto the wide output buses.
  always_comb begin
    str_reg   = '0;
    pat_reg   = '0;
    pat_len   = '0;
    ff_result = '0;
    for (int unsigned i = 0; i < MAX_STR; i++) str_reg[i*BYTE_W +: BYTE_W] = str_q[SIDX_W'(i)];
    for (int unsigned s = 0; s < NUM_PAT; s++) begin
      pat_len[s*PLEN_W +: PLEN_W] = pat_len_q[SLOT_W'(s)];
      for (int unsigned i = 0; i < MAX_PAT; i++) begin
        pat_reg[(s*MAX_PAT+i)*BYTE_W +: BYTE_W] = pat_q[SLOT_W'(s)][PIDX_W'(i)];
        ff_result[(s*MAX_PAT+i)*FF_W +: FF_W]   = ff_q[SLOT_W'(s)][PIDX_W'(i)];
      end
    end
  end

  assign w_ready = w_ready_q;
  assign valid   = valid_q;
  assign w_err   = w_err_q;
  assign str_len = str_len_q;

endmodule

// File: tb/tb_sme_multi_pat_buffer.sv
// Directed bench for sme_multi_pat_buffer (defaults: 32-char string, 2 slots of 8 chars).
module tb_sme_multi_pat_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   w_data;
  logic         write;
  logic [1:0]   w_sel;
  logic         w_ready;
  logic [255:0] str_reg;
  logic [127:0] pat_reg;
  logic [5:0]   str_len;
  logic [7:0]   pat_len;
  logic [47:0]  ff_result;
  logic         valid;
  logic         ack;
  logic         w_err;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  sme_multi_pat_buffer dut (
    .clk(clk), .reset(reset), .w_data(w_data), .write(write), .w_sel(w_sel),
    .w_ready(w_ready), .str_reg(str_reg), .pat_reg(pat_reg), .str_len(str_len),
    .pat_len(pat_len), .ff_result(ff_result), .valid(valid), .ack(ack), .w_err(w_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ffv(input logic [2:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic load_seq(input logic [1:0] sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      write = 1'b1; w_sel = sel; w_data = s[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic end_load(output int cyc);
    @(negedge clk);
    write = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_ack;
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; write = 1'b0; ack = 1'b0; w_sel = '0; w_data = '0;
    repeat (2) @(posedge clk); #1;
    tot_cnt++; if (w_ready !== 1'b1) $display("FAIL reset_w_ready got %0b exp 1", w_ready); else pass_cnt++;
    tot_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", valid); else pass_cnt++;
    tot_cnt++; if ({w_err, str_len, pat_len} !== 15'h0) $display("FAIL reset_len_err got %0h exp 0", {w_err, str_len, pat_len}); else pass_cnt++;
    tot_cnt++; if (ff_result !== 48'h0 || pat_reg !== 128'h0 || str_reg !== 256'h0) $display("FAIL reset_buffers got ff %0h exp 0", ff_result); else pass_cnt++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_abab;
    int cyc;
    load_seq(2'd0, "ABABC");
    load_seq(2'd1, "ABAB");
    end_load(cyc);
    tot_cnt++; if (cyc !== 5) $display("FAIL abab_ffcal_cycles got %0d exp 5", cyc); else pass_cnt++;
    tot_cnt++; if (str_len !== 6'd5) $display("FAIL abab_str_len got %0d exp 5", str_len); else pass_cnt++;
    tot_cnt++; if (pat_len !== 8'h04) $display("FAIL abab_pat_len got %0h exp 04", pat_len); else pass_cnt++;
    tot_cnt++; if (str_reg[39:0] !== 40'h4342414241) $display("FAIL abab_str_reg got %0h exp 4342414241", str_reg[39:0]); else pass_cnt++;
    tot_cnt++; if (pat_reg[31:0] !== 32'h42414241) $display("FAIL abab_pat_reg got %0h exp 42414241", pat_reg[31:0]); else pass_cnt++;
    tot_cnt++; if (ff_result[23:0] !== ffv(0,0,1,2,0,0,0,0)) $display("FAIL abab_ff got %0h exp %0h", ff_result[23:0], ffv(0,0,1,2,0,0,0,0)); else pass_cnt++;
    tot_cnt++; if (w_err !== 1'b0) $display("FAIL abab_w_err got %0b exp 0", w_err); else pass_cnt++;
    do_ack;
  endtask

  task automatic test_aaab;
    int cyc;
    load_seq(2'd1, "AAAB");
    end_load(cyc);
    tot_cnt++; if (cyc !== 7) $display("FAIL aaab_ffcal_cycles got %0d exp 7", cyc); else pass_cnt++;
    tot_cnt++; if (str_len !== 6'd0) $display("FAIL aaab_str_len got %0d exp 0", str_len); else pass_cnt++;
    tot_cnt++; if (ff_result[23:0] !== ffv(0,1,2,0,0,0,0,0)) $display("FAIL aaab_ff got %0h exp %0h", ff_result[23:0], ffv(0,1,2,0,0,0,0,0)); else pass_cnt++;
    do_ack;
  endtask

  task automatic test_slot1;
    int cyc;
    load_seq(2'd1, "AB");
    load_seq(2'd2, "ABACABAB");
    end_load(cyc);
    tot_cnt++; if (cyc !== 12) $display("FAIL slot1_ffcal_cycles got %0d exp 12", cyc); else pass_cnt++;
    tot_cnt++; if (pat_len !== 8'h82) $display("FAIL slot1_pat_len got %0h exp 82", pat_len); else pass_cnt++;
    tot_cnt++; if (ff_result[23:0] !== 24'h0) $display("FAIL slot1_ff0 got %0h exp 0", ff_result[23:0]); else pass_cnt++;
    tot_cnt++; if (ff_result[47:24] !== ffv(0,0,1,0,1,2,3,2)) $display("FAIL slot1_ff1 got %0h exp %0h", ff_result[47:24], ffv(0,0,1,0,1,2,3,2)); else pass_cnt++;
    do_ack;
  endtask

  task automatic test_two_slot;
    int cyc;
    load_seq(2'd1, "AAAA");
    end_load(cyc);
    tot_cnt++; if (cyc !== 5) $display("FAIL two_slot_ffcal_cycles got %0d exp 5", cyc); else pass_cnt++;
    tot_cnt++; if (pat_len !== 8'h04) $display("FAIL two_slot_pat_len got %0h exp 04", pat_len); else pass_cnt++;
    tot_cnt++; if (ff_result[23:0] !== ffv(0,1,2,3,0,0,0,0)) $display("FAIL two_slot_ff0 got %0h exp %0h", ff_result[23:0], ffv(0,1,2,3,0,0,0,0)); else pass_cnt++;
    tot_cnt++; if (ff_result[47:24] !== 24'h0) $display("FAIL two_slot_ff1 got %0h exp 0", ff_result[47:24]); else pass_cnt++;
    do_ack;
  endtask

  task automatic test_overflow;
    int cyc;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk); write = 1'b1; w_sel = 2'd1; w_data = 8'(8'h10 + b);
      @(posedge clk); #1;
    end
    load_seq(2'd3, "Z");
    end_load(cyc);
    tot_cnt++; if (cyc !== 9) $display("FAIL ovf_ffcal_cycles got %0d exp 9", cyc); else pass_cnt++;
    tot_cnt++; if (pat_len !== 8'h08) $display("FAIL ovf_pat_len got %0h exp 08", pat_len); else pass_cnt++;
    tot_cnt++; if (pat_reg[63:0] !== 64'h1716151413121110) $display("FAIL ovf_pat_reg got %0h exp 1716151413121110", pat_reg[63:0]); else pass_cnt++;
    tot_cnt++; if (w_err !== 1'b1) $display("FAIL ovf_w_err got %0b exp 1", w_err); else pass_cnt++;
    tot_cnt++; if (ff_result[23:0] !== 24'h0) $display("FAIL ovf_ff got %0h exp 0", ff_result[23:0]); else pass_cnt++;
    do_ack;
  endtask

  task automatic test_handshake;
    int cyc;
    bit bad = 1'b0;
    load_seq(2'd0, "X");
    tot_cnt++; if (w_err !== 1'b0) $display("FAIL hs_err_cleared got %0b exp 0", w_err); else pass_cnt++;
    end_load(cyc);
    tot_cnt++; if (cyc !== 2) $display("FAIL hs_ffcal_cycles got %0d exp 2", cyc); else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); write = 1'b1; w_sel = 2'd0; w_data = 8'h59;
      @(posedge clk); #1;
      if (valid !== 1'b1 || w_ready !== 1'b0) bad = 1'b1;
    end
    @(negedge clk); write = 1'b0;
    tot_cnt++; if (bad !== 1'b0) $display("FAIL hs_hold got bad=%0b exp 0", bad); else pass_cnt++;
    tot_cnt++; if ({str_len, str_reg[7:0]} !== {6'd1, 8'h58}) $display("FAIL hs_done_write got %0h exp 158", {str_len, str_reg[7:0]}); else pass_cnt++;
    do_ack;
    tot_cnt++; if ({valid, w_ready} !== 2'b01) $display("FAIL hs_ack got %0b exp 01", {valid, w_ready}); else pass_cnt++;
    load_seq(2'd1, "Q");
    tot_cnt++; if ({str_len, pat_len, w_err} !== {6'd0, 8'h01, 1'b0}) $display("FAIL hs_restart got %0h exp 2", {str_len, pat_len, w_err}); else pass_cnt++;
    end_load(cyc);
    do_ack;
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit bad = 1'b0;
    load_seq(2'd0, "ABC");
    load_seq(2'd1, "AAAB");
    @(negedge clk); write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    tot_cnt++; if ({valid, w_ready, w_err} !== 3'b010) $display("FAIL rmid_ctrl got %0b exp 010", {valid, w_ready, w_err}); else pass_cnt++;
    tot_cnt++; if ({str_len, pat_len} !== 14'h0 || ff_result !== 48'h0 || pat_reg !== 128'h0 || str_reg !== 256'h0) $display("FAIL rmid_clear got len %0h exp 0", {str_len, pat_len}); else pass_cnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) bad = 1'b1;
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) bad = 1'b1;
    end
    tot_cnt++; if (bad !== 1'b0) $display("FAIL rmid_no_valid got bad=%0b exp 0", bad); else pass_cnt++;
    load_seq(2'd1, "ABAB");
    end_load(cyc);
    tot_cnt++; if (cyc !== 5) $display("FAIL rmid_reload_cycles got %0d exp 5", cyc); else pass_cnt++;
    tot_cnt++; if (ff_result[23:0] !== ffv(0,0,1,2,0,0,0,0)) $display("FAIL rmid_reload_ff got %0h exp %0h", ff_result[23:0], ffv(0,0,1,2,0,0,0,0)); else pass_cnt++;
    do_ack;
  endtask

  initial begin
    test_reset;
    test_abab;
    test_aaab;
    test_slot1;
    test_two_slot;
    test_overflow;
    test_handshake;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/sme_multi_pat_buffer.md
Name: sme_multi_pat_buffer

Overview:
- Parametrised successor of the SME input buffer: byte-serially loads one string and up to NUM_PAT pattern slots, then computes the KMP failure function of every loaded pattern with an internal sequential engine.
- Sits between the host byte stream and the parallel string-matching engines.
- Adds a write-ready back-pressure signal, a valid/ack result hold, per-slot lengths, and overflow/illegal-select error flagging.

Parameters:
BYTE_W, 8, bits per character
MAX_STR, 32, string depth in characters
MAX_PAT, 8, pattern depth in characters per slot
NUM_PAT, 2, number of pattern slots
SEL_W, clog2(NUM_PAT+1), width of w_sel
SLEN_W, clog2(MAX_STR+1), width of str_len
PLEN_W, clog2(MAX_PAT+1), width of each pat_len entry
FF_W, clog2(MAX_PAT), width of each failure-function entry

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  reset, asynchronous, active-low
w_data  in  BYTE_W  byte to store
write  in  1  byte strobe, sampled when w_ready=1
w_sel  in  SEL_W  0 = string; k = pattern slot k-1 (1..NUM_PAT)
w_ready  out  1  buffer accepts writes (IDLE or LOAD)
str_reg  out  MAX_STR*BYTE_W  string bytes, char i at [i*BYTE_W +: BYTE_W]
pat_reg  out  NUM_PAT*MAX_PAT*BYTE_W  slot s char i at [(s*MAX_PAT+i)*BYTE_W +: BYTE_W]
str_len  out  SLEN_W  characters stored in string
pat_len  out  NUM_PAT*PLEN_W  characters stored per slot
ff_result  out  NUM_PAT*MAX_PAT*FF_W  failure function, slot s entry i at [(s*MAX_PAT+i)*FF_W +: FF_W]
valid  out  1  results stable, held until ack
ack  in  1  consumer releases buffer
w_err  out  1  sticky: overflow or illegal w_sel since last load start

Behaviour:
- Reset (reset=0, async): state IDLE; all buffers, lengths and ff_result cleared to 0; valid=0; w_err=0; w_ready=1.
- States: IDLE, LOAD, FF_CAL, DONE. w_ready=1 only in IDLE and LOAD.
- IDLE: write=1 -> LOAD. On the same edge: str_len, all pat_len and w_err clear to 0, then the byte is stored at index 0 of the selected target with its length set to 1.
- LOAD: each cycle with write=1 stores w_data at index len of the target, len+1. First cycle with write=0 -> FF_CAL.
- Bytes beyond a target's len retain stale values; consumers use the lengths.
- Overflow: write to a full target (len = depth) is dropped, len unchanged, w_err set. w_sel > NUM_PAT: write dropped, w_err set. Neither case aborts the load.
- FF_CAL: slots processed in order 0..NUM_PAT-1.
  - Per slot: one setup cycle (ff[0]=0, i=1, k=0, entries i>=len cleared to 0).
  - Then one KMP step per cycle while i<len:
    - pat[i]==pat[k]: k<=k+1, ff[i]<=k+1, i<=i+1.
    - else k>0: k<=ff[k-1].
    - else: ff[i]<=0, i<=i+1.
  - A slot with len<=1 uses only the setup cycle.
  - After the last slot -> DONE.
- Definition: ff[i] = length of the longest proper prefix of pat[0..i] that is also its suffix.
- DONE: valid=1 until ack sampled high. The ack edge -> IDLE, valid=0.
- ack outside DONE is ignored. write outside IDLE/LOAD is ignored and sets no flag.
- Outputs str_reg, pat_reg, lengths and ff_result are stable from DONE entry until the next IDLE->LOAD edge.
- Reset mid-load or mid-FF_CAL: immediate clear to the reset state; no partial valid.

Test Plan:
1. NUM_PAT=1; load string "ABABC" (w_sel=0), pattern "ABAB" (w_sel=1), write low -> str_len=5, pat_len=4; FF_CAL lasts 4 cycles; valid next cycle; ff={0,0,1,2}; w_err=0.
2. Pattern "AAAB" -> FF_CAL lasts 6 cycles (setup + 5 steps); ff={0,1,2,0}.
3. NUM_PAT=2; slot0 "AAAA", slot1 empty -> pat_len={4,0}; ff slot0={0,1,2,3}, slot1 all 0; FF_CAL lasts 4+1 cycles.
4. Overflow: write 10 pattern bytes into MAX_PAT=8 slot, plus one write with w_sel=3 -> pat_len=8, bytes 0..7 kept, w_err=1.
5. Handshake: hold ack=0 for 20 cycles in DONE -> valid stays 1, writes during DONE ignored (w_ready=0, lengths unchanged). Pulse ack -> valid=0 next cycle. New write -> lengths restart at 1, w_err=0.
6. Assert reset low mid-FF_CAL -> all outputs 0 asynchronously, w_ready=1, valid never pulses. After release, a full load completes normally.
